// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: FSM states, spi_mode bit positions
// and the per-mode table that selects which sclk edge samples pico.
package spi_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  localparam int unsigned MODE_CPOL_BIT = 1;
  localparam int unsigned MODE_CPHA_BIT = 0;

  // Indexed by {CPOL,CPHA}: 1 = sample on rising sclk, 0 = sample on falling.
  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling one.
  localparam logic [3:0] SAMPLE_ON_RISE = 4'b1001;

  function automatic logic sample_on_rise(input logic [1:0] mode);
    return SAMPLE_ON_RISE[mode];
  endfunction

endpackage

// File: rtl/spi_target_sync_if.sv
// Byte-level handshakes between the SPI target and its host logic.
interface spi_target_sync_if;
  // Both channels: a transfer happens on a clock edge where valid && ready;
  // the source holds data stable and valid high until that edge.
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_target_sync.sv
// SPI target (all four modes) oversampled by the system clock: sclk, pico and
// cs are synchronized, edges detected, and bytes exchanged via valid/ready.
module spi_target_sync
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [7:0]  IDLE_TX_BYTE = 8'h00
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] spi_mode,
  input  logic       sclk,
  input  logic       pico,
  input  logic       cs,
  output logic       poci,
  output logic       poci_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rx_overrun,
  output logic       tx_underrun,
  output logic [0:0] dbg_state
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  // cs idles high, so its synchronizer resets high to avoid a false edge.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clock), .rst_n(reset_n), .d(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clock), .rst_n(reset_n), .d(cs), .rise(cs_rise), .fall(cs_fall)
  );

  logic [SYNC_STAGES-1:0] pico_sync_q, pico_sync_d;
  logic                   pico_s;

  spi_state_e state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_overrun_q, rx_overrun_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_full_q, tx_full_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_underrun_q, tx_underrun_d;

  logic cpha, on_rise, sample_edge, shift_edge, byte_start;

  always_comb begin
    pico_sync_d = {pico_sync_q[SYNC_STAGES-2:0], pico};
    pico_s      = pico_sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q && !rx_ready;
    rx_overrun_d  = 1'b0;
    tx_buf_d      = tx_buf_q;
    tx_full_d     = tx_full_q;
    tx_shift_d    = tx_shift_q;
    tx_underrun_d = 1'b0;
    byte_start    = 1'b0;

    // Mode is only tracked while the bus is deselected.
    mode_d  = (state_q == ST_IDLE && !cs_fall) ? spi_mode : mode_q;
    cpha    = mode_q[MODE_CPHA_BIT];
    on_rise = sample_on_rise(mode_q);
    sample_edge = (state_q == ST_ACTIVE) && (on_rise ? sclk_rise : sclk_fall);
    shift_edge  = (state_q == ST_ACTIVE) && (on_rise ? sclk_fall : sclk_rise);

    if (tx_valid && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d    = ST_ACTIVE;
          bit_cnt_d  = 3'd0;
          tx_shift_d = '0;
          byte_start = !cpha;
        end
      end
      default: begin
        if (cs_rise) begin
          // A partial byte is simply abandoned.
          state_d   = ST_IDLE;
          bit_cnt_d = 3'd0;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[5:0], pico_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_valid_q && !rx_ready) begin
                rx_overrun_d = 1'b1;
              end else begin
                rx_data_d  = {rx_shift_q, pico_s};
                rx_valid_d = 1'b1;
              end
            end
          end
          if (shift_edge) begin
            if (cpha && bit_cnt_q == 3'd0) byte_start = 1'b1;
            else tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
    endcase

    // A load above only happens when empty, so it never collides with this.
    if (byte_start) begin
      if (tx_full_q) begin
        tx_shift_d = tx_buf_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d    = IDLE_TX_BYTE;
        tx_underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pico_sync_q   <= '0;
      state_q       <= ST_IDLE;
      mode_q        <= 2'b00;
      bit_cnt_q     <= 3'd0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_buf_q      <= '0;
      tx_full_q     <= 1'b0;
      tx_shift_q    <= '0;
      tx_underrun_q <= 1'b0;
    end else begin
      pico_sync_q   <= pico_sync_d;
      state_q       <= state_d;
      mode_q        <= mode_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      tx_shift_q    <= tx_shift_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign poci_oe     = (state_q == ST_ACTIVE);
  assign poci        = (state_q == ST_ACTIVE) && tx_shift_q[7];
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = !tx_full_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_target_sync.sv
// Bench for spi_target_sync: a behavioural SPI controller plus a byte-level
// reference model of the target's rx/tx buffering and error pulses.
module tb_spi_target_sync;

  localparam logic [7:0] IDLE_BYTE = 8'hFF;

  // clock / reset
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [1:0] spi_mode = 2'b00;
  logic       sclk = 1'b0;
  logic       pico = 1'b0;
  logic       cs = 1'b1;
  logic       poci, poci_oe, rx_overrun, tx_underrun;
  logic [0:0] dbg_state;

  spi_target_sync_if bus ();

  spi_target_sync #(.SYNC_STAGES(2), .IDLE_TX_BYTE(IDLE_BYTE)) dut (
    .clock(clock), .reset_n(reset_n), .spi_mode(spi_mode),
    .sclk(sclk), .pico(pico), .cs(cs), .poci(poci), .poci_oe(poci_oe),
    .rx_data(bus.rx_data), .rx_valid(bus.rx_valid), .rx_ready(bus.rx_ready),
    .tx_data(bus.tx_data), .tx_valid(bus.tx_valid), .tx_ready(bus.tx_ready),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .dbg_state(dbg_state)
  );

  // scoreboard and reference model
  int n_checks = 0;
  int n_errors = 0;
  int ovr_cnt = 0;
  int und_cnt = 0;
  int exp_ovr = 0;
  int exp_und = 0;
  logic [7:0] exp_q[$];
  bit         m_full = 1'b0;
  logic [7:0] m_buf = '0;
  bit         m_pend = 1'b0;
  logic [7:0] m_pend_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rx_overrun) ovr_cnt++;
    if (tx_underrun) und_cnt++;
    if (bus.rx_valid && bus.rx_ready) begin
      check_eq("rx_byte_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_eq("rx_data", bus.rx_data, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load_tx(input logic [7:0] b);
    check_eq("tx_ready_pre_load", bus.tx_ready, 1);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.tx_valid = 1'b0;
    m_buf  = b;
    m_full = 1'b1;
    check_eq("tx_ready_post_load", bus.tx_ready, 0);
  endtask

  task automatic set_ready(input bit v);
    if (v && m_pend) begin
      exp_q.push_back(m_pend_data);
      m_pend = 1'b0;
    end
    bus.rx_ready = v;
  endtask

  // Controller at clock/8: each sclk half period is four system clocks.
  task automatic spi_frame(input logic [1:0] mode, input logic [7:0] mosi, input int nbits,
                           input bit rst_mid, output logic [7:0] miso);
    logic cpol, cpha;
    logic [7:0] sh;
    cpol = mode[1];
    cpha = mode[0];
    sh   = mosi;
    miso = '0;
    spi_mode = mode;
    sclk = cpol;
    pico = sh[7];
    wait_clk(6);
    cs = 1'b0;
    wait_clk(4);
    check_eq("frame_active", dbg_state, 1);
    check_eq("frame_oe", poci_oe, 1);
    for (int i = 0; i < nbits; i++) begin
      if (cpha) begin
        pico = sh[7];
        sh = sh << 1;
      end else begin
        miso = {miso[6:0], poci};
      end
      sclk = ~cpol;
      wait_clk(4);
      if (cpha) begin
        miso = {miso[6:0], poci};
      end else begin
        sh = sh << 1;
        pico = sh[7];
      end
      sclk = cpol;
      wait_clk(4);
    end
    if (rst_mid) begin
      reset_n = 1'b0;
      wait_clk(3);
      cs = 1'b1;
      wait_clk(3);
      reset_n = 1'b1;
    end else begin
      cs = 1'b1;
    end
  endtask

  task automatic do_frame(input logic [1:0] mode, input logic [7:0] mosi, input int nbits,
                          input bit rst_mid);
    logic [7:0] miso, exp_miso;
    // Any frame with at least one bit starts a byte and consumes the buffer.
    exp_miso = m_full ? m_buf : IDLE_BYTE;
    if (!m_full) exp_und++;
    m_full = 1'b0;
    if (nbits == 8) begin
      if (bus.rx_ready) exp_q.push_back(mosi);
      else if (m_pend) exp_ovr++;
      else begin
        m_pend = 1'b1;
        m_pend_data = mosi;
      end
    end
    spi_frame(mode, mosi, nbits, rst_mid, miso);
    if (rst_mid) m_pend = 1'b0;
    wait_clk(8);
    check_eq("state_idle", dbg_state, 0);
    check_eq("oe_idle", poci_oe, 0);
    check_eq("poci_idle", poci, 0);
    check_eq("rx_drained", exp_q.size(), 0);
    check_eq("overruns", ovr_cnt, exp_ovr);
    check_eq("underruns", und_cnt, exp_und);
    check_eq("tx_ready", bus.tx_ready, !m_full);
    if (m_pend) begin
      check_eq("rx_valid_held", bus.rx_valid, 1);
      check_eq("rx_data_held", bus.rx_data, m_pend_data);
    end else begin
      check_eq("rx_valid_low", bus.rx_valid, 0);
    end
    if (nbits == 8 && !rst_mid) check_eq("miso", miso, exp_miso);
  endtask

  initial begin
    bus.rx_ready = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    wait_clk(3);
    check_eq("rst_rx_valid", bus.rx_valid, 0);
    check_eq("rst_rx_data", bus.rx_data, 0);
    check_eq("rst_tx_ready", bus.tx_ready, 1);
    check_eq("rst_poci_oe", poci_oe, 0);
    check_eq("rst_poci", poci, 0);
    check_eq("rst_ovr", rx_overrun, 0);
    check_eq("rst_und", tx_underrun, 0);
    check_eq("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    wait_clk(4);
    set_ready(1'b1);

    // A5 out, 3C in, in every mode
    for (int m = 0; m < 4; m++) begin
      load_tx(8'hA5);
      do_frame(2'(m), 8'h3C, 8, 1'b0);
    end

    // rx held off across two bytes
    set_ready(1'b0);
    do_frame(2'd0, 8'h11, 8, 1'b0);
    do_frame(2'd0, 8'h22, 8, 1'b0);
    set_ready(1'b1);
    wait_clk(4);
    check_eq("overrun_drained", exp_q.size(), 0);

    // empty tx buffer
    do_frame(2'd2, 8'h96, 8, 1'b0);

    // partial byte then a full one
    do_frame(2'd1, 8'hE7, 5, 1'b0);
    do_frame(2'd1, 8'h5A, 8, 1'b0);

    // reset after three bits, then a clean byte
    load_tx(8'h4D);
    do_frame(2'd3, 8'h99, 3, 1'b1);
    do_frame(2'd3, 8'hC3, 8, 1'b0);

    // randomized traffic
    for (int k = 0; k < 24; k++) begin
      logic [1:0] m;
      int nb;
      m = 2'($urandom_range(0, 3));
      if (!m_full && $urandom_range(0, 1) == 1) load_tx(8'($urandom_range(0, 255)));
      set_ready($urandom_range(0, 3) != 0);
      nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 8;
      do_frame(m, 8'($urandom_range(0, 255)), nb, 1'b0);
    end
    set_ready(1'b1);
    wait_clk(4);
    check_eq("final_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_target_sync.md
SPI_TARGET_SYNC -- requirements
Module: spi_target_sync

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, which sets the number of synchronizer flops on sclk, pico and cs (minimum 2).
REQ-002 SHALL have parameter IDLE_TX_BYTE, default 8'h00, which is the byte shifted out when no tx byte is buffered.
REQ-003 SHALL have port clock, input, 1 bit: system clock, all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port spi_mode, input, 2 bits: {CPOL,CPHA}, sampled only while cs is high.
REQ-006 SHALL have port sclk, input, 1 bit: SPI clock from the controller, asynchronous.
REQ-007 SHALL have port pico, input, 1 bit: controller-to-target data, MSB first.
REQ-008 SHALL have port cs, input, 1 bit: chip select, active low.
REQ-009 SHALL have port poci, output, 1 bit: target-to-controller data.
REQ-010 SHALL have port poci_oe, output, 1 bit: poci drive enable; the top level builds the tristate.
REQ-011 SHALL have ports rx_data (output, 8 bits), rx_valid (output, 1 bit) and rx_ready (input, 1 bit): received-byte valid/ready handshake.
REQ-012 SHALL have ports tx_data (input, 8 bits), tx_valid (input, 1 bit) and tx_ready (output, 1 bit): byte-to-send handshake.
REQ-013 SHALL have ports rx_overrun and tx_underrun, output, 1 bit each: single-cycle error pulses.

Function
REQ-014 SHALL pass sclk, pico and cs through SYNC_STAGES flops each, and SHALL detect edges on the synchronized sclk and cs only.
REQ-015 SHALL implement the FSM IDLE -> ACTIVE on the synchronized cs falling edge, and ACTIVE -> IDLE on the synchronized cs rising edge from any bit position.
REQ-016 SHALL define the leading edge as rising when CPOL=0 and falling when CPOL=1; the sample edge is the leading edge when CPHA=0, otherwise the trailing edge; the other edge is the shift edge.
REQ-017 SHALL sample pico into an 8-bit shift register on each sample edge in ACTIVE, and SHALL count bits 0..7, wrapping to 0 after bit 7.
REQ-018 SHALL, on the 8th sample, present the completed byte with rx_valid high on the following clock; rx_valid SHALL hold until rx_valid&&rx_ready.
REQ-019 SHALL, if a byte completes while rx_valid is still high, drop the new byte, keep rx_data unchanged, and pulse rx_overrun for 1 cycle.
REQ-020 SHALL hold one tx buffer entry; tx_ready SHALL equal buffer-empty, and tx_valid&&tx_ready SHALL load the buffer.
REQ-021 SHALL load the tx shift register from the buffer at byte start, emptying the buffer; if the buffer is empty it SHALL load IDLE_TX_BYTE and pulse tx_underrun.
REQ-022 SHALL define byte start as the cs falling edge when CPHA=0, and the first shift edge of each byte when CPHA=1.
REQ-023 SHALL place the MSB on poci at byte start, and SHALL advance one bit on each subsequent shift edge within the byte.
REQ-024 SHALL drive poci_oe high only in ACTIVE and poci low in IDLE.
REQ-025 SHALL discard a partial byte when cs rises: no rx_valid, the bit counter is cleared, and the tx buffer is kept.
REQ-026 SHALL require a clock frequency of at least 8x the sclk frequency; sclk edges with cs high SHALL be ignored.

Reset
REQ-027 SHALL, while reset_n is low, asynchronously clear the FSM to IDLE, clear the counters, shift registers, rx_data, rx_valid, rx_overrun, tx_underrun, poci and poci_oe, and set tx_ready=1.
REQ-028 SHALL return to IDLE on reset mid-byte, and SHALL NOT report the partial byte after release.

Structure
REQ-029 SHALL place the FSM state enum, the spi_mode bit positions and the per-mode edge-select constants in shared package spi_pkg.
REQ-030 SHALL instantiate the sub-module spi_sync_edge (N-stage synchronizer with rise/fall pulse outputs) once each for sclk and cs, and SHALL use a plain synchronizer for pico.

Verification
REQ-031 SHALL cover mode 0, tx buffer holding 8'hA5, controller sending 8'h3C at clock/8 -> rx_data=8'h3C with rx_valid, and the controller receiving 8'hA5.
REQ-032 SHALL cover modes 1, 2 and 3 each with the same 8'h3C/8'hA5 exchange -> identical results, using the same controller stimulus as the dummy peripherals.
REQ-033 SHALL cover rx_ready held low across two bytes 8'h11 then 8'h22 -> rx_data stays 8'h11 and one rx_overrun pulse occurs.
REQ-034 SHALL cover an empty tx buffer with IDLE_TX_BYTE=8'hFF -> controller receives 8'hFF and one tx_underrun pulse occurs.
REQ-035 SHALL cover cs raised after 5 bits, followed by a full byte 8'h5A -> no rx_valid for the partial byte and rx_data=8'h5A afterwards.
REQ-036 SHALL cover reset_n asserted after 3 bits, then released, followed by byte 8'hC3 -> rx_data=8'hC3 and no spurious rx_valid.
